mips_multicycle_ctrl: RTL and testbench

//  Sequencing controller for the MIPS datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mips_ctrl_pkg.sv | 82 ++++++++
 rtl/mips_ctrl_decoder.sv | 91 +++++++++
 rtl/mips_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS controller: state codes, ISA fields,
// ALU op codes, datapath mux selects, error codes and the decoder output bundle.
package mips_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [1:0] RWS_R31 = 2'd0;
  localparam logic [1:0] RWS_RT  = 2'd1;
  localparam logic [1:0] RWS_RD  = 2'd2;

  localparam logic [1:0] PCS_RS     = 2'd0;
  localparam logic [1:0] PCS_JUMP   = 2'd1;
  localparam logic [1:0] PCS_BRANCH = 2'd2;
  localparam logic [1:0] PCS_PC4    = 2'd3;

  localparam logic ALUB_IMM  = 1'b0;
  localparam logic ALUB_RT   = 1'b1;
  localparam logic MOS_MEM   = 1'b0;
  localparam logic MOS_ALU   = 1'b1;
  localparam logic JALS_PC   = 1'b0;
  localparam logic JALS_DATA = 1'b1;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_FETCH_TO = 2'd2;
  localparam logic [1:0] ERR_MEM_TO   = 2'd3;

  typedef enum logic [2:0] {
    IC_NONE   = 3'd0,
    IC_ALU    = 3'd1,
    IC_LOAD   = 3'd2,
    IC_STORE  = 3'd3,
    IC_BRANCH = 3'd4,
    IC_JUMP   = 3'd5,
    IC_JR     = 3'd6
  } insn_class_e;

  typedef struct packed {
    insn_class_e cls;
    logic [2:0]  alu_op;
    logic        alu_b_sel;
    logic [1:0]  reg_write_sel;
    logic [1:0]  pc_sel;
    logic        mem_out_sel;
    logic        jal_sel;
    logic        slt_sel;
    logic        writes_reg;
    logic        illegal;
  } dec_t;

  function automatic logic is_mem_class(input insn_class_e cls);
    return (cls == IC_LOAD) || (cls == IC_STORE);
  endfunction

endpackage

// File: rtl/mips_ctrl_decoder.sv
// Combinational instruction classifier: opcode/funct to class, ALU op and datapath selects.
// Selects that an instruction does not use are left at 0.
module mips_ctrl_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        dec_o.cls           = IC_ALU;
        dec_o.alu_b_sel     = ALUB_RT;
        dec_o.reg_write_sel = RWS_RD;
        dec_o.pc_sel        = PCS_PC4;
        dec_o.mem_out_sel   = MOS_ALU;
        dec_o.jal_sel       = JALS_DATA;
        dec_o.writes_reg    = 1'b1;
        case (funct_i)
          FN_ADD:  dec_o.alu_op = ALU_ADD;
          FN_SUB:  dec_o.alu_op = ALU_SUB;
          FN_AND:  dec_o.alu_op = ALU_AND;
          FN_OR:   dec_o.alu_op = ALU_OR;
          FN_SLT: begin
            dec_o.alu_op  = ALU_SUB;
            dec_o.slt_sel = 1'b1;
          end
          FN_JR: begin
            dec_o        = '0;
            dec_o.cls    = IC_JR;
            dec_o.pc_sel = PCS_RS;
          end
          default: begin
            dec_o         = '0;
            dec_o.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        dec_o.cls           = IC_ALU;
        dec_o.alu_b_sel     = ALUB_IMM;
        dec_o.reg_write_sel = RWS_RT;
        dec_o.pc_sel        = PCS_PC4;
        dec_o.mem_out_sel   = MOS_ALU;
        dec_o.jal_sel       = JALS_DATA;
        dec_o.writes_reg    = 1'b1;
        dec_o.alu_op        = (opcode_i == OP_SLTI) ? ALU_SUB : ALU_ADD;
        dec_o.slt_sel       = (opcode_i == OP_SLTI);
      end
      OP_LW: begin
        dec_o.cls           = IC_LOAD;
        dec_o.alu_op        = ALU_ADD;
        dec_o.alu_b_sel     = ALUB_IMM;
        dec_o.reg_write_sel = RWS_RT;
        dec_o.pc_sel        = PCS_PC4;
        dec_o.mem_out_sel   = MOS_MEM;
        dec_o.jal_sel       = JALS_DATA;
        dec_o.writes_reg    = 1'b1;
      end
      OP_SW: begin
        dec_o.cls       = IC_STORE;
        dec_o.alu_op    = ALU_ADD;
        dec_o.alu_b_sel = ALUB_IMM;
        dec_o.pc_sel    = PCS_PC4;
      end
      OP_BEQ: begin
        // Taken/not-taken is resolved from the zero flag in the top.
        dec_o.cls       = IC_BRANCH;
        dec_o.alu_op    = ALU_SUB;
        dec_o.alu_b_sel = ALUB_RT;
        dec_o.pc_sel    = PCS_PC4;
      end
      OP_J: begin
        dec_o.cls    = IC_JUMP;
        dec_o.pc_sel = PCS_JUMP;
      end
      OP_JAL: begin
        dec_o.cls           = IC_JUMP;
        dec_o.pc_sel        = PCS_JUMP;
        dec_o.reg_write_sel = RWS_R31;
        dec_o.jal_sel       = JALS_PC;
        dec_o.writes_reg    = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller with instruction/data memory handshakes and wait timeouts.
// Define CTRL_PERF_CNT_EN to add the cycle_count / instret_count performance counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] instruction_bus,
  input  logic        zer,
  input  logic        inst_ready,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        reg_write_en,
  output logic        pc_load_en,
  output logic        ALU_B_sel,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic        mem_out_sel,
  output logic        slt_ALU_sel,
  output logic        jal_sel,
  output logic [1:0]  reg_write_sel,
  output logic [1:0]  pc_next_sel,
  output logic [2:0]  ALU_op_code,
  output logic        halted,
  output logic [1:0]  err_code
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`endif
);

  localparam int TMR_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       err_q, err_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [5:0]       funct_q, funct_d;
  dec_t             dec_s;
  logic             sel_active_s;
  logic             unused_insn_bits_s;

  assign unused_insn_bits_s = ^instruction_bus[25:6];

  mips_ctrl_decoder u_decoder (
    .opcode_i (opcode_q),
    .funct_i  (funct_q),
    .dec_o    (dec_s)
  );

  // Next-state, wait timer and error capture; the timer restarts on every state exit.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    err_d    = err_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (inst_ready) begin
          state_d  = ST_DECODE;
          timer_d  = '0;
          opcode_d = instruction_bus[31:26];
          funct_d  = instruction_bus[5:0];
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_HALT;
          timer_d = '0;
          err_d   = ERR_FETCH_TO;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_DECODE: begin
        if (dec_s.illegal) begin
          state_d = ST_HALT;
          err_d   = ERR_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_mem_class(dec_s.cls)) state_d = ST_MEM;
        else                         state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_WB;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_HALT;
          timer_d = '0;
          err_d   = ERR_MEM_TO;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WB: begin
        // run only matters here and in IDLE, so a stop lands on an instruction boundary.
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      err_q    <= ERR_NONE;
      opcode_q <= 6'd0;
      funct_q  <= 6'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  assign sel_active_s = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                        (state_q == ST_MEM)    || (state_q == ST_WB);

  // Datapath controls decoded from the registered state and the latched instruction.
  always_comb begin
    reg_write_en = 1'b0;
    pc_load_en   = 1'b0;
    mem_req      = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    halted       = 1'b0;
    if (sel_active_s) begin
      ALU_B_sel     = dec_s.alu_b_sel;
      mem_out_sel   = dec_s.mem_out_sel;
      slt_ALU_sel   = dec_s.slt_sel;
      jal_sel       = dec_s.jal_sel;
      reg_write_sel = dec_s.reg_write_sel;
      ALU_op_code   = dec_s.alu_op;
      pc_next_sel   = ((dec_s.cls == IC_BRANCH) && zer) ? PCS_BRANCH : dec_s.pc_sel;
    end else begin
      ALU_B_sel     = 1'b0;
      mem_out_sel   = 1'b0;
      slt_ALU_sel   = 1'b0;
      jal_sel       = 1'b0;
      reg_write_sel = 2'd0;
      ALU_op_code   = 3'd0;
      pc_next_sel   = 2'd0;
    end
    case (state_q)
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_read_en  = (dec_s.cls == IC_LOAD);
        mem_write_en = (dec_s.cls == IC_STORE);
      end
      ST_WB: begin
        pc_load_en   = 1'b1;
        reg_write_en = dec_s.writes_reg;
      end
      ST_HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign err_code = err_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instret_cnt_q;

  // Free-running performance counters; both wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (state_q != ST_HALT)) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end else begin
        cycle_cnt_q <= cycle_cnt_q;
      end
      if (state_q == ST_WB) begin
        instret_cnt_q <= instret_cnt_q + CNT_W'(1);
      end else begin
        instret_cnt_q <= instret_cnt_q;
      end
    end
  end

  assign cycle_count   = cycle_cnt_q;
  assign instret_count = instret_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: each cycle the expected control vector is pushed to a
// scoreboard queue and popped against the DUT outputs half a cycle later.
module tb_mips_multicycle_ctrl;

  typedef enum int {PH_IDLE, PH_FETCH, PH_DEC, PH_EXEC, PH_MEM, PH_WB, PH_HALT} ph_e;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] instruction_bus;
  logic        zer;
  logic        inst_ready;
  logic        mem_ready;
  logic        mem_req, reg_write_en, pc_load_en, ALU_B_sel, mem_write_en, mem_read_en;
  logic        mem_out_sel, slt_ALU_sel, jal_sel, halted;
  logic [1:0]  reg_write_sel, pc_next_sel, err_code;
  logic [2:0]  ALU_op_code;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_count, instret_count;
`endif

  logic [18:0] obs_s;
  logic [18:0] exp_q[$];
  logic [1:0]  exp_err;
  int          checks;
  int          errors;

  localparam logic [31:0] I_ADD  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_SUB  = {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h22};
  localparam logic [31:0] I_AND  = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h24};
  localparam logic [31:0] I_OR   = {6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h25};
  localparam logic [31:0] I_SLT  = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h2A};
  localparam logic [31:0] I_JR   = {6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08};
  localparam logic [31:0] I_BADF = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F};
  localparam logic [31:0] I_ADDI = {6'h08, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_SLTI = {6'h0A, 5'd1, 5'd2, 16'h0020};
  localparam logic [31:0] I_LW   = {6'h23, 5'd1, 5'd2, 16'h0004};
  localparam logic [31:0] I_SW   = {6'h2B, 5'd1, 5'd2, 16'h0008};
  localparam logic [31:0] I_BEQ  = {6'h04, 5'd1, 5'd2, 16'h0003};
  localparam logic [31:0] I_J    = {6'h02, 26'h0000100};
  localparam logic [31:0] I_JAL  = {6'h03, 26'h0000200};
  localparam logic [31:0] I_BADO = {6'h3F, 26'h0000000};

  mips_multicycle_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .instruction_bus (instruction_bus),
    .zer             (zer),
    .inst_ready      (inst_ready),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .reg_write_en    (reg_write_en),
    .pc_load_en      (pc_load_en),
    .ALU_B_sel       (ALU_B_sel),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_out_sel     (mem_out_sel),
    .slt_ALU_sel     (slt_ALU_sel),
    .jal_sel         (jal_sel),
    .reg_write_sel   (reg_write_sel),
    .pc_next_sel     (pc_next_sel),
    .ALU_op_code     (ALU_op_code),
    .halted          (halted),
    .err_code        (err_code)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_count     (cycle_count),
    .instret_count   (instret_count)
`endif
  );

  assign obs_s = {reg_write_en, pc_load_en, ALU_B_sel, mem_write_en, mem_read_en, mem_out_sel,
                  slt_ALU_sel, jal_sel, reg_write_sel, pc_next_sel, ALU_op_code, mem_req,
                  halted, err_code};

  always #5 clk = ~clk;

  // Reference control vector; selects an instruction does not use are expected at 0.
  function automatic logic [18:0] model(ph_e ph, logic [31:0] ins, logic zr, logic [1:0] err);
    logic [5:0] opc, fn;
    logic       alub, mos, jals, slt, wr, ld, st, rwe, pce, mw, mr, mreq, hlt;
    logic [1:0] rws, pcs;
    logic [2:0] alu;
    opc = ins[31:26];
    fn  = ins[5:0];
    {alub, mos, jals, slt, wr, ld, st} = 7'b0;
    {rwe, pce, mw, mr, mreq, hlt} = 6'b0;
    rws = 2'd0; pcs = 2'd0; alu = 3'd0;
    case (opc)
      6'h00: begin
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
          rws = 2'd2; pcs = 2'd3; alub = 1'b1; mos = 1'b1; jals = 1'b1; wr = 1'b1;
          alu = (fn == 6'h20) ? 3'd0 : (fn == 6'h24) ? 3'd2 : (fn == 6'h25) ? 3'd3 : 3'd1;
          slt = (fn == 6'h2A);
        end else if (fn == 6'h08) begin
          pcs = 2'd0;
        end
      end
      6'h08: begin rws = 2'd1; pcs = 2'd3; mos = 1'b1; jals = 1'b1; wr = 1'b1; end
      6'h0A: begin rws = 2'd1; pcs = 2'd3; mos = 1'b1; jals = 1'b1; wr = 1'b1; alu = 3'd1; slt = 1'b1; end
      6'h23: begin rws = 2'd1; pcs = 2'd3; jals = 1'b1; wr = 1'b1; ld = 1'b1; end
      6'h2B: begin pcs = 2'd3; st = 1'b1; end
      6'h04: begin alub = 1'b1; alu = 3'd1; pcs = zr ? 2'd2 : 2'd3; end
      6'h02: pcs = 2'd1;
      6'h03: begin pcs = 2'd1; wr = 1'b1; end
      default: pcs = 2'd0;
    endcase
    if (ph inside {PH_IDLE, PH_FETCH, PH_HALT}) begin
      {alub, mos, jals, slt} = 4'b0; rws = 2'd0; pcs = 2'd0; alu = 3'd0;
    end
    if (ph == PH_MEM) begin mreq = 1'b1; mr = ld; mw = st; end
    if (ph == PH_WB)  begin pce = 1'b1; rwe = wr; end
    hlt = (ph == PH_HALT);
    return {rwe, pce, alub, mw, mr, mos, slt, jals, rws, pcs, alu, mreq, hlt, err};
  endfunction

  task automatic check(input string tag);
    logic [18:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs_s === e) else begin
      errors++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs_s, e);
    end
  endtask

  task automatic cycle(input ph_e ph, input string tag);
    exp_q.push_back(model(ph, instruction_bus, zer, exp_err));
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    run = 1'b0;
    exp_err = 2'd0;
    #1;
    exp_q.push_back(model(PH_IDLE, instruction_bus, zer, 2'd0));
    check(tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_insn(input logic [31:0] ins, input logic zr, input int fwait, input int mwait,
                         input bit run_after, input bit drop_in_exec, input bit from_idle,
                         input string tag);
    instruction_bus = ins;
    zer = zr;
    run = 1'b1;
    mem_ready = 1'b1;
    inst_ready = 1'b0;
    if (from_idle) cycle(PH_IDLE, {tag, "_idle"});
    for (int i = 0; i < fwait; i++) cycle(PH_FETCH, {tag, "_fwait"});
    inst_ready = 1'b1;
    cycle(PH_FETCH, {tag, "_fetch"});
    inst_ready = 1'b0;
    cycle(PH_DEC, {tag, "_decode"});
    if (drop_in_exec) run = 1'b0;
    cycle(PH_EXEC, {tag, "_exec"});
    if (ins[31:26] == 6'h23 || ins[31:26] == 6'h2B) begin
      mem_ready = 1'b0;
      for (int i = 0; i < mwait; i++) cycle(PH_MEM, {tag, "_mwait"});
      mem_ready = 1'b1;
      cycle(PH_MEM, {tag, "_mem"});
    end
    if (!drop_in_exec) run = run_after;
    cycle(PH_WB, {tag, "_wb"});
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; run = 1'b0; instruction_bus = 32'd0; zer = 1'b0;
    inst_ready = 1'b0; mem_ready = 1'b0; exp_err = 2'd0; checks = 0; errors = 0;
    #2;
    exp_q.push_back(model(PH_IDLE, instruction_bus, zer, 2'd0));
    check("reset_state");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    cycle(PH_IDLE, "idle_hold");
    cycle(PH_IDLE, "idle_hold");

    do_insn(I_ADD, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "add");
    do_insn(I_LW,  1'b0, 0, 2, 1'b0, 1'b0, 1'b1, "lw_delay");
    do_insn(I_SW,  1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "sw");
    do_insn(I_BEQ, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, "beq_taken");
    do_insn(I_BEQ, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "beq_not");
    do_insn(I_J,   1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "j");
    do_insn(I_JAL, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "jal");
    do_insn(I_JR,  1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "jr");

    do_insn(I_SUB,  1'b0, 0, 0, 1'b1, 1'b0, 1'b1, "sub");
    do_insn(I_AND,  1'b0, 0, 0, 1'b1, 1'b0, 1'b0, "and");
    do_insn(I_OR,   1'b0, 0, 0, 1'b1, 1'b0, 1'b0, "or");
    do_insn(I_SLT,  1'b0, 0, 0, 1'b1, 1'b0, 1'b0, "slt");
    do_insn(I_ADDI, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, "addi");
    do_insn(I_SLTI, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "slti");

    do_insn(I_ADD, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, "add_fwait");
    do_insn(I_LW,  1'b0, 10, 10, 1'b0, 1'b0, 1'b1, "lw_timer_clear");
    do_insn(I_ADD, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, "run_drop_exec");
    inst_ready = 1'b1;
    cycle(PH_IDLE, "run_drop_idle");
    cycle(PH_IDLE, "run_drop_idle");

    // Illegal opcode halts from DECODE and stays halted.
    instruction_bus = I_BADO; run = 1'b1; inst_ready = 1'b1; mem_ready = 1'b1;
    cycle(PH_IDLE, "bad_op_idle");
    cycle(PH_FETCH, "bad_op_fetch");
    cycle(PH_DEC, "bad_op_decode");
    exp_err = 2'd1;
    for (int i = 0; i < 3; i++) cycle(PH_HALT, "bad_op_halt");
    do_reset("bad_op_reset");

    instruction_bus = I_BADF; run = 1'b1; inst_ready = 1'b1;
    cycle(PH_IDLE, "bad_fn_idle");
    cycle(PH_FETCH, "bad_fn_fetch");
    cycle(PH_DEC, "bad_fn_decode");
    exp_err = 2'd1;
    cycle(PH_HALT, "bad_fn_halt");
    do_reset("bad_fn_reset");

    instruction_bus = I_ADD; run = 1'b1; inst_ready = 1'b0;
    cycle(PH_IDLE, "fetch_to_idle");
    for (int i = 0; i < 16; i++) cycle(PH_FETCH, "fetch_to_wait");
    exp_err = 2'd2;
    cycle(PH_HALT, "fetch_to_halt");
    inst_ready = 1'b1;
    cycle(PH_HALT, "fetch_to_halt");
    do_reset("fetch_to_reset");

    instruction_bus = I_LW; run = 1'b1; inst_ready = 1'b1; mem_ready = 1'b0;
    cycle(PH_IDLE, "mem_to_idle");
    cycle(PH_FETCH, "mem_to_fetch");
    cycle(PH_DEC, "mem_to_decode");
    cycle(PH_EXEC, "mem_to_exec");
    for (int i = 0; i < 16; i++) cycle(PH_MEM, "mem_to_wait");
    exp_err = 2'd3;
    cycle(PH_HALT, "mem_to_halt");
    mem_ready = 1'b1;
    cycle(PH_HALT, "mem_to_halt");
    do_reset("mem_to_reset");

    instruction_bus = I_LW; run = 1'b1; inst_ready = 1'b1; mem_ready = 1'b0;
    cycle(PH_IDLE, "rst_mem_idle");
    cycle(PH_FETCH, "rst_mem_fetch");
    cycle(PH_DEC, "rst_mem_decode");
    cycle(PH_EXEC, "rst_mem_exec");
    cycle(PH_MEM, "rst_mem_mem");
    cycle(PH_MEM, "rst_mem_mem");
    do_reset("rst_mid_mem");
    cycle(PH_IDLE, "rst_mem_after");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
